// File: rtl/mu0_run_monitor.sv
// mu0_run_monitor: run controller and bus monitor for the MU0 processor.
// Holds MU0 in reset for RST_CYCLES after Start, counts run cycles until
// Halted or the watchdog fires, and logs processor memory writes.
// Optional feature macro: MU0_WRLOG_EN builds the write-log FIFO; without it
// all Log_* outputs are tied to 0 and Log_Rd is ignored.
// Dbg_State exposes the controller state (0 IDLE, 1 RSTP, 2 RUN, 3 DONE).
// Log read handshake: Log_Valid high means Log_Addr/Log_Data hold the head
// entry; Log_Rd sampled high with Log_Valid high pops it at that edge, and
// Log_Rd while Log_Valid is low has no effect.
module mu0_run_monitor #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 16,
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 1000,
    parameter int LOG_DEPTH  = 8
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         Start,
    output logic                         Cpu_Reset,
    input  logic                         Halted,
    input  logic                         Wr,
    input  logic [ADDR_W-1:0]            Addr,
    input  logic [DATA_W-1:0]            Dout,
    output logic                         Done,
    output logic                         Timed_out,
    output logic [31:0]                  Cycles,
    input  logic                         Log_Rd,
    output logic                         Log_Valid,
    output logic [ADDR_W-1:0]            Log_Addr,
    output logic [DATA_W-1:0]            Log_Data,
    output logic [$clog2(LOG_DEPTH):0]   Log_Count,
    output logic                         Log_Overflow,
    output logic [1:0]                   Dbg_State
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RSTP = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam int RC_W   = $clog2(RST_CYCLES + 1);
    localparam int LOG_AW = $clog2(LOG_DEPTH);

    logic [1:0]      state;
    logic [RC_W-1:0] rst_cnt;
    logic [31:0]     cycles;
    logic [31:0]     cycles_inc;
    logic            timed_out;

    // Saturating run-cycle increment; the count never wraps.
    always_comb begin
        cycles_inc = cycles;
        if (cycles != 32'hFFFF_FFFF) begin
            cycles_inc = cycles + 32'd1;
        end
    end

    // Run control FSM; halt takes priority over the watchdog in the same cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            rst_cnt   <= '0;
            cycles    <= '0;
            timed_out <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        state     <= RSTP;
                        rst_cnt   <= '0;
                        cycles    <= '0;
                        timed_out <= 1'b0;
                    end
                end
                RSTP: begin
                    if (rst_cnt == RC_W'(RST_CYCLES - 1)) begin
                        state <= RUN;
                    end else begin
                        rst_cnt <= rst_cnt + RC_W'(1);
                    end
                end
                RUN: begin
                    cycles <= cycles_inc;
                    if (Halted) begin
                        state <= DONE;
                    end else if ((TIMEOUT != 0) && (cycles_inc == 32'(TIMEOUT))) begin
                        state     <= DONE;
                        timed_out <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Cpu_Reset = (state == IDLE) || (state == RSTP);
    assign Done      = (state == DONE);
    assign Timed_out = timed_out;
    assign Cycles    = cycles;
    assign Dbg_State = state;

`ifdef MU0_WRLOG_EN
    logic [ADDR_W-1:0] log_addr_mem [LOG_DEPTH];
    logic [DATA_W-1:0] log_data_mem [LOG_DEPTH];
    logic [LOG_AW-1:0] wr_ptr;
    logic [LOG_AW-1:0] rd_ptr;
    logic [LOG_AW:0]   count;
    logic              overflow;
    logic              start_accept;
    logic              run_wr;
    logic              full;
    logic              empty;
    logic              do_push;
    logic              do_pop;
    logic              drop;

    assign start_accept = Start && ((state == IDLE) || (state == DONE));
    assign run_wr       = Wr && (state == RUN);
    assign full         = (count == (LOG_AW + 1)'(LOG_DEPTH));
    assign empty        = (count == '0);
    assign do_pop       = Log_Rd && !empty;
    // A pop in the same cycle frees the slot, so a push into a full log succeeds.
    assign do_push      = run_wr && (!full || do_pop);
    assign drop         = run_wr && full && !do_pop;

    // Log pointers, occupancy and sticky overflow; a new run empties the log.
    always_ff @(posedge Clk) begin
        if (Reset || start_accept) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + LOG_AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + LOG_AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (LOG_AW + 1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (LOG_AW + 1)'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Log storage; contents need no reset since count gates visibility.
    always_ff @(posedge Clk) begin
        if (do_push) begin
            log_addr_mem[wr_ptr] <= Addr;
            log_data_mem[wr_ptr] <= Dout;
        end
    end

    assign Log_Valid    = !empty;
    assign Log_Addr     = log_addr_mem[rd_ptr];
    assign Log_Data     = log_data_mem[rd_ptr];
    assign Log_Count    = count;
    assign Log_Overflow = overflow;
`else
    logic unused_log_inputs;

    assign unused_log_inputs = ^{Log_Rd, Wr, Addr, Dout};
    assign Log_Valid    = 1'b0;
    assign Log_Addr     = '0;
    assign Log_Data     = '0;
    assign Log_Count    = '0;
    assign Log_Overflow = 1'b0;
`endif

endmodule

// File: tb/tb_mu0_run_monitor.sv
// tb_mu0_run_monitor: directed bench for mu0_run_monitor with RST_CYCLES=2,
// TIMEOUT=20, LOG_DEPTH=8. Log contents are checked when MU0_WRLOG_EN is
// defined; otherwise the Log_* outputs are checked to stay 0.
module tb_mu0_run_monitor;

    localparam int ADDR_W     = 12;
    localparam int DATA_W     = 16;
    localparam int RST_CYCLES = 2;
    localparam int TIMEOUT    = 20;
    localparam int LOG_DEPTH  = 8;

    logic              clk;
    logic              reset;
    logic              start;
    logic              cpu_reset;
    logic              halted;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dout;
    logic              done;
    logic              timed_out;
    logic [31:0]       cycles;
    logic              log_rd;
    logic              log_valid;
    logic [ADDR_W-1:0] log_addr;
    logic [DATA_W-1:0] log_data;
    logic [3:0]        log_count;
    logic              log_overflow;
    logic [1:0]        dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic [ADDR_W+DATA_W-1:0] exp_e;

    mu0_run_monitor #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .RST_CYCLES (RST_CYCLES),
        .TIMEOUT    (TIMEOUT),
        .LOG_DEPTH  (LOG_DEPTH)
    ) dut (
        .Clk          (clk),
        .Reset        (reset),
        .Start        (start),
        .Cpu_Reset    (cpu_reset),
        .Halted       (halted),
        .Wr           (wr),
        .Addr         (addr),
        .Dout         (dout),
        .Done         (done),
        .Timed_out    (timed_out),
        .Cycles       (cycles),
        .Log_Rd       (log_rd),
        .Log_Valid    (log_valid),
        .Log_Addr     (log_addr),
        .Log_Data     (log_data),
        .Log_Count    (log_count),
        .Log_Overflow (log_overflow),
        .Dbg_State    (dbg_state)
    );

    // Clock: 10 ns period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and return at the following falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse Start for one edge; returns in the first RSTP cycle
    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic log_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr   = 1'b1;
        addr = a;
        dout = d;
        tick();
        wr = 1'b0;
    endtask

    task automatic chk_log_zero(input string tag);
        chk({tag, "_log_valid"}, 32'(log_valid), 32'd0);
        chk({tag, "_log_count"}, 32'(log_count), 32'd0);
        chk({tag, "_log_ovf"}, 32'(log_overflow), 32'd0);
        chk({tag, "_log_addr"}, 32'(log_addr), 32'd0);
        chk({tag, "_log_data"}, 32'(log_data), 32'd0);
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        halted = 1'b0;
        wr     = 1'b0;
        addr   = '0;
        dout   = '0;
        log_rd = 1'b0;
        @(negedge clk);
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_timed_out", 32'(timed_out), 32'd0);
        chk("rst_cycles", cycles, 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        chk("rst_log_valid", 32'(log_valid), 32'd0);
        chk("rst_log_count", 32'(log_count), 32'd0);
        chk("rst_log_ovf", 32'(log_overflow), 32'd0);
        tick();
        chk("idle_hold_state", 32'(dbg_state), 32'd0);

        // Run 1: Cpu_Reset held for exactly 2 cycles, halt on run cycle 5
        pulse_start();
        chk("r1_rstp_c1_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("r1_rstp_state", 32'(dbg_state), 32'd1);
        tick();
        chk("r1_rstp_c2_cpu_reset", 32'(cpu_reset), 32'd1);
        tick();
        chk("r1_run_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("r1_run_done", 32'(done), 32'd0);
        chk("r1_run_state", 32'(dbg_state), 32'd2);
        for (int i = 0; i < 4; i++) tick();
        chk("r1_c5_cycles_before", cycles, 32'd4);
        halted = 1'b1;
        tick();
        halted = 1'b0;
        chk("r1_done", 32'(done), 32'd1);
        chk("r1_cycles", cycles, 32'd5);
        chk("r1_timed_out", 32'(timed_out), 32'd0);
        chk("r1_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("r1_state", 32'(dbg_state), 32'd3);
        tick();
        chk("r1_cycles_frozen", cycles, 32'd5);
        chk("r1_done_held", 32'(done), 32'd1);

        // Run 2: watchdog at 20 cycles; Start in RUN is ignored
        pulse_start();
        chk("r2_start_clears_done", 32'(done), 32'd0);
        chk("r2_start_clears_cycles", cycles, 32'd0);
        chk("r2_cpu_reset", 32'(cpu_reset), 32'd1);
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("r2_start_ignored_cycles", cycles, 32'd1);
        chk("r2_start_ignored_cpu_reset", 32'(cpu_reset), 32'd0);
        for (int i = 0; i < 18; i++) tick();
        chk("r2_c20_cycles_before", cycles, 32'd19);
        chk("r2_c20_done_before", 32'(done), 32'd0);
        tick();
        chk("r2_done", 32'(done), 32'd1);
        chk("r2_timed_out", 32'(timed_out), 32'd1);
        chk("r2_cycles", cycles, 32'd20);

        // Run 3: halt on cycle 20 beats the watchdog
        pulse_start();
        chk("r3_start_clears_timed_out", 32'(timed_out), 32'd0);
        tick();
        tick();
        for (int i = 0; i < 19; i++) tick();
        halted = 1'b1;
        tick();
        halted = 1'b0;
        chk("r3_done", 32'(done), 32'd1);
        chk("r3_timed_out", 32'(timed_out), 32'd0);
        chk("r3_cycles", cycles, 32'd20);

`ifdef MU0_WRLOG_EN
        // Run 4: 10 writes into an 8-deep log, then drain in DONE
        pulse_start();
        tick();
        tick();
        exp_q.delete();
        for (int i = 0; i < 10; i++) begin
            log_write(ADDR_W'(12'h010 + i), DATA_W'(16'hA000 + i));
            if (exp_q.size() < LOG_DEPTH) exp_q.push_back({ADDR_W'(12'h010 + i), DATA_W'(16'hA000 + i)});
            if (i == 0) begin
                chk("r4_first_valid", 32'(log_valid), 32'd1);
                chk("r4_first_addr", 32'(log_addr), 32'h010);
                chk("r4_first_data", 32'(log_data), 32'hA000);
                chk("r4_first_count", 32'(log_count), 32'd1);
            end
        end
        chk("r4_full_count", 32'(log_count), 32'd8);
        chk("r4_overflow", 32'(log_overflow), 32'd1);
        halted = 1'b1;
        tick();
        halted = 1'b0;
        wr = 1'b1;
        tick();
        wr = 1'b0;
        chk("r4_done_write_ignored", 32'(log_count), 32'd8);
        while (exp_q.size() > 0) begin
            exp_e = exp_q.pop_front();
            chk("r4_pop_valid", 32'(log_valid), 32'd1);
            chk("r4_pop_addr", 32'(log_addr), 32'(exp_e[ADDR_W+DATA_W-1:DATA_W]));
            chk("r4_pop_data", 32'(log_data), 32'(exp_e[DATA_W-1:0]));
            log_rd = 1'b1;
            tick();
            log_rd = 1'b0;
        end
        chk("r4_drained_valid", 32'(log_valid), 32'd0);
        chk("r4_drained_count", 32'(log_count), 32'd0);
        log_rd = 1'b1;
        tick();
        log_rd = 1'b0;
        chk("r4_empty_pop_count", 32'(log_count), 32'd0);
        chk("r4_ovf_sticky", 32'(log_overflow), 32'd1);

        // Run 5: push and pop together on a full log
        pulse_start();
        chk("r5_start_clears_ovf", 32'(log_overflow), 32'd0);
        tick();
        tick();
        for (int i = 0; i < LOG_DEPTH; i++) begin
            log_write(ADDR_W'(12'h100 + i), DATA_W'(16'hB000 + i));
            exp_q.push_back({ADDR_W'(12'h100 + i), DATA_W'(16'hB000 + i)});
        end
        chk("r5_full_count", 32'(log_count), 32'd8);
        log_rd = 1'b1;
        log_write(12'h1FF, 16'hBEEF);
        log_rd = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back({12'h1FF, 16'hBEEF});
        chk("r5_pushpop_count", 32'(log_count), 32'd8);
        chk("r5_pushpop_ovf", 32'(log_overflow), 32'd0);
        halted = 1'b1;
        tick();
        halted = 1'b0;
        while (exp_q.size() > 0) begin
            exp_e = exp_q.pop_front();
            chk("r5_pop_addr", 32'(log_addr), 32'(exp_e[ADDR_W+DATA_W-1:DATA_W]));
            chk("r5_pop_data", 32'(log_data), 32'(exp_e[DATA_W-1:0]));
            log_rd = 1'b1;
            tick();
            log_rd = 1'b0;
        end
        chk("r5_drained_valid", 32'(log_valid), 32'd0);
`else
        chk_log_zero("nolog_after_runs");
`endif

        // Run 6: Reset in the middle of RUN with 3 writes logged
        pulse_start();
        tick();
        tick();
        for (int i = 0; i < 3; i++) log_write(ADDR_W'(12'h200 + i), DATA_W'(16'hC000 + i));
`ifdef MU0_WRLOG_EN
        chk("r6_count_before", 32'(log_count), 32'd3);
`else
        chk_log_zero("nolog_run_writes");
        log_rd = 1'b1;
        tick();
        log_rd = 1'b0;
        chk_log_zero("nolog_rd_ignored");
`endif
        chk("r6_cycles_before", 32'(cycles != 0), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("r6_state", 32'(dbg_state), 32'd0);
        chk("r6_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("r6_cycles", cycles, 32'd0);
        chk("r6_log_count", 32'(log_count), 32'd0);
        chk("r6_log_valid", 32'(log_valid), 32'd0);
        chk("r6_done", 32'(done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
